// File: rtl/dev_init_pkg.sv
// Shared types and default widths for the dev_initiator bus-master front end.
//   op_e    : command opcodes carried on cmd_op / rsp_op
//   state_e : initiator sequencing states
package dev_init_pkg;

  localparam int unsigned DEF_ADDRESS_W = 2;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned OP_W          = 2;

  typedef enum logic [1:0] {
    OP_WR      = 2'b00,
    OP_RD      = 2'b01,
    OP_WR_DUAL = 2'b10,
    OP_RD_DUAL = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT0 = 3'd1,
    ST_BEAT1 = 3'd2,
    ST_CAP   = 3'd3,
    ST_RSP   = 3'd4
  } state_e;

endpackage

// File: rtl/dev_initiator.sv
// dev_initiator: initiator side of the 4-entry memory device pin protocol.
// Accepts one command at a time, sequences the device enables (single beat or
// the mandatory two-beat dual pair), captures read data and returns exactly one
// response per command.
//
// Configuration macro: DEV_INITIATOR_DUAL_EN
//   defined   : WR_DUAL / RD_DUAL supported
//   undefined : any dual op is answered with an error response, dual enables
//               stay 0
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-low reset
//   i_cmd_* / o_cmd_ready        command channel (valid/ready)
//   o_rsp_* / i_rsp_ready        response channel (valid/ready)
//   o_dev_* / i_dev_data_rd      device pins
module dev_initiator
  import dev_init_pkg::*;
#(
  parameter int unsigned ADDRESS_W = DEF_ADDRESS_W,
  parameter int unsigned DATA_W    = DEF_DATA_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [OP_W-1:0]      i_cmd_op,
  input  logic [ADDRESS_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0]    i_cmd_wdata0,
  input  logic [DATA_W-1:0]    i_cmd_wdata1,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [OP_W-1:0]      o_rsp_op,
  output logic [DATA_W-1:0]    o_rsp_rdata0,
  output logic [DATA_W-1:0]    o_rsp_rdata1,
  output logic                 o_rsp_err,
  output logic [ADDRESS_W-1:0] o_dev_address,
  output logic                 o_dev_write_en,
  output logic                 o_dev_write_dual_en,
  output logic                 o_dev_read_en,
  output logic                 o_dev_read_dual_en,
  output logic [DATA_W-1:0]    o_dev_data_wr,
  input  logic [DATA_W-1:0]    i_dev_data_rd
);

`ifdef DEV_INITIATOR_DUAL_EN
  localparam bit DUAL_EN = 1'b1;
`else
  localparam bit DUAL_EN = 1'b0;
`endif

  // A dual pair starting at the last entry would run the device past its array.
  localparam logic [ADDRESS_W-1:0] LAST_ADDR = '1;

  state_e              r_state;
  op_e                 r_op;
  logic [DATA_W-1:0]   r_wdata1;
  logic [DATA_W-1:0]   r_rdata0;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic [OP_W-1:0]     r_rsp_op;
  logic [DATA_W-1:0]   r_rsp_rdata0;
  logic [DATA_W-1:0]   r_rsp_rdata1;
  logic                r_rsp_err;
  logic [ADDRESS_W-1:0] r_dev_address;
  logic                r_dev_we;
  logic                r_dev_wde;
  logic                r_dev_re;
  logic                r_dev_rde;
  logic [DATA_W-1:0]   r_dev_data_wr;

  logic w_accept;
  logic w_reject;

  assign w_accept = i_cmd_valid && r_cmd_ready;
  assign w_reject = i_cmd_op[1] && (!DUAL_EN || (i_cmd_addr == LAST_ADDR));

  // Sequencer: state plus every registered output, updated together so the
  // device pins are always the decode of the state being entered.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= ST_IDLE;
      r_op          <= OP_WR;
      r_wdata1      <= '0;
      r_rdata0      <= '0;
      r_cmd_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_op      <= '0;
      r_rsp_rdata0  <= '0;
      r_rsp_rdata1  <= '0;
      r_rsp_err     <= 1'b0;
      r_dev_address <= '0;
      r_dev_we      <= 1'b0;
      r_dev_wde     <= 1'b0;
      r_dev_re      <= 1'b0;
      r_dev_rde     <= 1'b0;
      r_dev_data_wr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op        <= op_e'(i_cmd_op);
            r_wdata1    <= i_cmd_wdata1;
            r_cmd_ready <= 1'b0;
            if (w_reject) begin
              r_state      <= ST_RSP;
              r_rsp_valid  <= 1'b1;
              r_rsp_op     <= i_cmd_op;
              r_rsp_err    <= 1'b1;
              r_rsp_rdata0 <= '0;
              r_rsp_rdata1 <= '0;
            end else begin
              r_state       <= ST_BEAT0;
              r_dev_address <= i_cmd_addr;
              r_dev_data_wr <= i_cmd_wdata0;
              r_dev_we      <= (op_e'(i_cmd_op) == OP_WR);
              r_dev_re      <= (op_e'(i_cmd_op) == OP_RD);
              r_dev_wde     <= DUAL_EN && (op_e'(i_cmd_op) == OP_WR_DUAL);
              r_dev_rde     <= DUAL_EN && (op_e'(i_cmd_op) == OP_RD_DUAL);
            end
          end
        end

        ST_BEAT0: begin
          r_dev_we <= 1'b0;
          r_dev_re <= 1'b0;
          if (DUAL_EN && r_op[1]) begin
            // Dual enable stays high and the address stays put; the device
            // applies the +1 offset on the second beat itself.
            r_state       <= ST_BEAT1;
            r_dev_data_wr <= r_wdata1;
          end else if (r_op == OP_RD) begin
            r_state <= ST_CAP;
          end else begin
            r_state      <= ST_RSP;
            r_rsp_valid  <= 1'b1;
            r_rsp_op     <= OP_W'(r_op);
            r_rsp_err    <= 1'b0;
            r_rsp_rdata0 <= '0;
            r_rsp_rdata1 <= '0;
          end
        end

        ST_BEAT1: begin
          r_dev_wde <= 1'b0;
          r_dev_rde <= 1'b0;
          if (r_op == OP_RD_DUAL) begin
            r_rdata0 <= i_dev_data_rd;
            r_state  <= ST_CAP;
          end else begin
            r_state      <= ST_RSP;
            r_rsp_valid  <= 1'b1;
            r_rsp_op     <= OP_W'(r_op);
            r_rsp_err    <= 1'b0;
            r_rsp_rdata0 <= '0;
            r_rsp_rdata1 <= '0;
          end
        end

        ST_CAP: begin
          r_state      <= ST_RSP;
          r_rsp_valid  <= 1'b1;
          r_rsp_op     <= OP_W'(r_op);
          r_rsp_err    <= 1'b0;
          r_rsp_rdata0 <= (r_op == OP_RD) ? i_dev_data_rd : r_rdata0;
          r_rsp_rdata1 <= (r_op == OP_RD_DUAL) ? i_dev_data_rd : '0;
        end

        ST_RSP: begin
          if (i_rsp_ready) begin
            r_state      <= ST_IDLE;
            r_cmd_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_op     <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata0 <= '0;
            r_rsp_rdata1 <= '0;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_dev_we    <= 1'b0;
          r_dev_wde   <= 1'b0;
          r_dev_re    <= 1'b0;
          r_dev_rde   <= 1'b0;
        end
      endcase
    end
  end

  assign o_cmd_ready         = r_cmd_ready;
  assign o_rsp_valid         = r_rsp_valid;
  assign o_rsp_op            = r_rsp_op;
  assign o_rsp_rdata0        = r_rsp_rdata0;
  assign o_rsp_rdata1        = r_rsp_rdata1;
  assign o_rsp_err           = r_rsp_err;
  assign o_dev_address       = r_dev_address;
  assign o_dev_write_en      = r_dev_we;
  assign o_dev_read_en       = r_dev_re;
  assign o_dev_write_dual_en = r_dev_wde & DUAL_EN;
  assign o_dev_read_dual_en  = r_dev_rde & DUAL_EN;
  assign o_dev_data_wr       = r_dev_data_wr;

endmodule

// File: tb/tb_dev_initiator.sv
// Bench for dev_initiator, paired with a behavioural 4-entry device.
// The expected responses come from a plain memory array updated per command.
module tb_dev_initiator;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 8;
`ifdef DEV_INITIATOR_DUAL_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]    cmd_op, rsp_op;
  logic [AW-1:0] cmd_addr, dev_address;
  logic [DW-1:0] cmd_wdata0, cmd_wdata1, rsp_rdata0, rsp_rdata1;
  logic          dev_we, dev_wde, dev_re, dev_rde;
  logic [DW-1:0] dev_data_wr, dev_data_rd;

  dev_initiator #(.ADDRESS_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata0(cmd_wdata0), .i_cmd_wdata1(cmd_wdata1),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_op(rsp_op),
    .o_rsp_rdata0(rsp_rdata0), .o_rsp_rdata1(rsp_rdata1), .o_rsp_err(rsp_err),
    .o_dev_address(dev_address), .o_dev_write_en(dev_we),
    .o_dev_write_dual_en(dev_wde), .o_dev_read_en(dev_re),
    .o_dev_read_dual_en(dev_rde), .o_dev_data_wr(dev_data_wr),
    .i_dev_data_rd(dev_data_rd)
  );

  // Behavioural device: registered read data, dual beats use a toggling offset.
  logic [DW-1:0] dmem [4];
  logic          doff;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) dmem[i] <= 8'hFF;
      doff        <= 1'b0;
      dev_data_rd <= '0;
    end else begin
      if (dev_we) dmem[dev_address] <= dev_data_wr;
      if (dev_re) dev_data_rd <= dmem[dev_address];
      if (dev_wde) begin
        dmem[2'(dev_address + 2'(doff))] <= dev_data_wr;
        doff <= ~doff;
      end
      if (dev_rde) begin
        dev_data_rd <= dmem[2'(dev_address + 2'(doff))];
        doff <= ~doff;
      end
    end
  end

  // Reference model state
  int            errors = 0;
  int            checks = 0;
  bit            in_flight = 1'b0;
  logic [DW-1:0] mmem [4];
  logic [1:0]    exp_op;
  logic [DW-1:0] exp_r0, exp_r1;
  logic          exp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mmem[i] = 8'hFF;
    in_flight = 1'b0;
  endtask

  // Compute the expected response and update the model memory for one command.
  task automatic model_cmd(input logic [1:0] op, input logic [1:0] a,
                           input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                           output int lat);
    logic [1:0] a1;
    a1      = 2'(a + 2'd1);
    exp_op  = op;
    exp_err = op[1] && (!DUAL || a == 2'd3);
    exp_r0  = '0;
    exp_r1  = '0;
    if (!exp_err) begin
      case (op)
        2'd0: mmem[a] = w0;
        2'd1: exp_r0 = mmem[a];
        2'd2: begin mmem[a] = w0; mmem[a1] = w1; end
        default: begin exp_r0 = mmem[a]; exp_r1 = mmem[a1]; end
      endcase
    end
    if (exp_err)        lat = 1;
    else if (op == 2'd0) lat = 2;
    else if (op == 2'd3) lat = 4;
    else                lat = 3;
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("one_enable", 32'($countones({dev_we, dev_wde, dev_re, dev_rde}) <= 1), 32'd1);
      chk("cmd_ready", 32'(cmd_ready), 32'(!in_flight));
      if (rsp_valid) begin
        chk("rsp_in_flight", 32'(in_flight), 32'd1);
        chk("rsp_op", 32'(rsp_op), 32'(exp_op));
        chk("rsp_rdata0", 32'(rsp_rdata0), 32'(exp_r0));
        chk("rsp_rdata1", 32'(rsp_rdata1), 32'(exp_r1));
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      end
    end
  end

  // Issue one command, watch the device pins until the response, optionally
  // stall the response while offering a competing command, then consume it.
  task automatic do_cmd(input logic [1:0] op, input logic [1:0] a,
                        input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                        input int stall,
                        output logic [DW-1:0] r0, output logic [DW-1:0] r1,
                        output logic err);
    int lat, exp_lat, n_we, n_wde, n_re, n_rde, first_d, last_d;
    bit got, addr_ok, ok_err;
    @(negedge clk);
    model_cmd(op, a, w0, w1, exp_lat);
    ok_err = exp_err;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata0 = w0; cmd_wdata1 = w1;
    @(posedge clk);
    in_flight = 1'b1;
    #1 cmd_valid = 1'b0;
    got = 1'b0; lat = 0; addr_ok = 1'b1;
    n_we = 0; n_wde = 0; n_re = 0; n_rde = 0; first_d = -1; last_d = -1;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      n_we  += int'(dev_we);  n_re  += int'(dev_re);
      n_wde += int'(dev_wde); n_rde += int'(dev_rde);
      if (dev_we || dev_re || dev_wde || dev_rde)
        if (dev_address != a) addr_ok = 1'b0;
      if (dev_wde || dev_rde) begin
        if (first_d < 0) first_d = c;
        last_d = c;
      end
      if (rsp_valid) begin got = 1'b1; lat = c; end
    end
    chk("rsp_arrived", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("n_write_en", 32'(n_we), 32'((!ok_err && op == 2'd0) ? 1 : 0));
    chk("n_read_en", 32'(n_re), 32'((!ok_err && op == 2'd1) ? 1 : 0));
    chk("n_write_dual_en", 32'(n_wde), 32'((!ok_err && op == 2'd2) ? 2 : 0));
    chk("n_read_dual_en", 32'(n_rde), 32'((!ok_err && op == 2'd3) ? 2 : 0));
    chk("dev_address", 32'(addr_ok), 32'd1);
    if (!ok_err && op[1]) chk("dual_consecutive", 32'(last_d - first_d), 32'd1);
    r0 = rsp_rdata0; r1 = rsp_rdata1; err = rsp_err;
    for (int s = 0; s < stall; s++) begin
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 2'd3; cmd_wdata0 = 8'hEE; cmd_wdata1 = 8'hEE;
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rdata0", 32'(rsp_rdata0), 32'(r0));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    in_flight = 1'b0;
    #1 rsp_ready = 1'b0;
  endtask

  logic [DW-1:0] r0, r1;
  logic          err;

  initial begin
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata0 = '0; cmd_wdata1 = '0;
    rsp_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_enables", 32'({dev_we, dev_wde, dev_re, dev_rde}), 32'd0);
    chk("rst_dev_address", 32'(dev_address), 32'd0);
    chk("rst_dev_data_wr", 32'(dev_data_wr), 32'd0);
    chk("rst_rsp_fields", 32'({rsp_op, rsp_rdata0, rsp_rdata1, rsp_err}), 32'd0);
    #1 rst_n = 1'b1;

    // Read of untouched memory
    do_cmd(2'd1, 2'd2, 8'h00, 8'h00, 0, r0, r1, err);
    chk("lit_rd2_ff", 32'(r0), 32'hFF);
    chk("lit_rd2_err", 32'(err), 32'd0);

    // Single write then read back
    do_cmd(2'd0, 2'd1, 8'h5A, 8'h00, 0, r0, r1, err);
    do_cmd(2'd1, 2'd1, 8'h00, 8'h00, 0, r0, r1, err);
    chk("lit_rd1_5a", 32'(r0), 32'h5A);
    chk("lit_rd1_r1_zero", 32'(r1), 32'h00);

    // Dual write then dual read
    do_cmd(2'd2, 2'd0, 8'h11, 8'h22, 0, r0, r1, err);
    do_cmd(2'd3, 2'd0, 8'h00, 8'h00, 0, r0, r1, err);
    if (DUAL) begin
      chk("lit_rdd0_r0", 32'(r0), 32'h11);
      chk("lit_rdd0_r1", 32'(r1), 32'h22);
    end else begin
      chk("lit_rdd0_err", 32'(err), 32'd1);
    end

    // Dual at the last address is rejected
    do_cmd(2'd3, 2'd3, 8'h00, 8'h00, 0, r0, r1, err);
    chk("lit_rdd3_err", 32'(err), 32'd1);

    // Further patterns, model-checked
    do_cmd(2'd2, 2'd2, 8'hA5, 8'hC3, 0, r0, r1, err);
    do_cmd(2'd3, 2'd1, 8'h00, 8'h00, 0, r0, r1, err);
    do_cmd(2'd0, 2'd3, 8'h77, 8'h00, 0, r0, r1, err);

    // Response stalled for 5 cycles while a competing write is offered
    do_cmd(2'd1, 2'd0, 8'h00, 8'h00, 5, r0, r1, err);
    do_cmd(2'd1, 2'd3, 8'h00, 8'h00, 0, r0, r1, err);
    chk("lit_rd3_77", 32'(r0), 32'h77);

    // Reset during the second beat of a dual write
    @(negedge clk);
    begin
      int dummy;
      model_cmd(2'd2, 2'd1, 8'h99, 8'h88, dummy);
    end
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = 2'd1; cmd_wdata0 = 8'h99; cmd_wdata1 = 8'h88;
    @(posedge clk);
    in_flight = 1'b1;
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("beat0_dual_en", 32'(dev_wde), 32'(DUAL));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_enables", 32'({dev_we, dev_wde, dev_re, dev_rde}), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    model_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
    do_cmd(2'd0, 2'd2, 8'h3C, 8'h00, 0, r0, r1, err);
    do_cmd(2'd1, 2'd2, 8'h00, 8'h00, 0, r0, r1, err);
    chk("lit_post_rst_rd2", 32'(r0), 32'h3C);
    do_cmd(2'd1, 2'd1, 8'h00, 8'h00, 0, r0, r1, err);
    chk("lit_post_rst_rd1", 32'(r0), 32'hFF);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
